// File: rtl/rot_pkg.sv
// Shared widths and operand types for the pipelined rotate-left unit.
package rot_pkg;

    localparam int unsigned ROT_W   = 32;
    localparam int unsigned ROT_SHW = $clog2(ROT_W);

    typedef logic [ROT_W-1:0]   rot_data_t;
    typedef logic [ROT_SHW-1:0] rot_amt_t;

endpackage : rot_pkg

// File: rtl/rotl_pipe_if.sv
// Operand/result handshake bundle for rotl_pipe: producer-side and consumer-side valid/ready.
interface rotl_pipe_if
    import rot_pkg::*;
#(
    parameter int unsigned WIDTH = ROT_W,
    parameter int unsigned SHW   = $clog2(WIDTH)
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Pipeline side
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_amt,
        output out_valid,
        input  out_ready,
        output out_data
    );

    // Environment side: feeds operands and consumes results
    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_amt,
        input  out_valid,
        output out_ready,
        input  out_data
    );

endinterface : rotl_pipe_if

// File: rtl/rotl_stage.sv
// One pipeline stage: conditionally rotates left by 2^K and registers valid/data/amount.
module rotl_stage
    import rot_pkg::*;
#(
    parameter int unsigned WIDTH = ROT_W,
    parameter int unsigned SHW   = $clog2(WIDTH),
    parameter int unsigned K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic [SHW-1:0]   i_amt,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [SHW-1:0]   o_amt
);

    localparam int unsigned SH = 1 << K;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_amt;
    logic [WIDTH-1:0] w_rot;

    always_comb begin
        w_rot = i_data;
        if (i_amt[K]) begin
            w_rot = {i_data[WIDTH-1-SH:0], i_data[WIDTH-1:WIDTH-SH]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= w_rot;
            r_amt   <= i_amt;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_amt   = r_amt;

endmodule : rotl_stage

// File: rtl/rotl_pipe.sv
// Pipelined rotate-left: SHW conditional-rotate stages with a bubble-collapsing stall chain.
module rotl_pipe
    import rot_pkg::*;
#(
    parameter int unsigned WIDTH = ROT_W,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        rst,
    rotl_pipe_if.slave  bus
);

    // Index 0 is the pipeline input, index k+1 the output of stage k.
    logic             w_valid [SHW+1];
    logic [WIDTH-1:0] w_data  [SHW+1];
    logic [SHW-1:0]   w_amt   [SHW+1];
    logic [SHW-1:0]   w_en;
    logic             w_unused_amt;

    assign w_valid[0] = bus.in_valid;
    assign w_data[0]  = bus.in_data;
    assign w_amt[0]   = bus.in_amt;

    // A stage may load when it is empty or when everything downstream of it moves.
    always_comb begin
        w_en = '0;
        w_en[SHW-1] = ~w_valid[SHW] | bus.out_ready;
        for (int unsigned k = SHW - 1; k > 0; k--) begin
            w_en[k-1] = ~w_valid[k] | w_en[k];
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        rotl_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .K     (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_en    (w_en[k]),
            .i_valid (w_valid[k]),
            .i_data  (w_data[k]),
            .i_amt   (w_amt[k]),
            .o_valid (w_valid[k+1]),
            .o_data  (w_data[k+1]),
            .o_amt   (w_amt[k+1])
        );
    end

    assign bus.in_ready  = w_en[0];
    assign bus.out_valid = w_valid[SHW];
    assign bus.out_data  = w_data[SHW];

    // The final amount has no consumer; it is carried only to keep stages uniform.
    assign w_unused_amt = ^w_amt[SHW];

    a_out_hold: assert property (
        @(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_data))
    );

endmodule : rotl_pipe

// File: tb/tb_rotl_pipe.sv
// Directed and randomised checks of rotl_pipe against a shift-based rotate model.
module tb_rotl_pipe;
    import rot_pkg::*;

    localparam int unsigned W  = ROT_W;
    localparam int unsigned S  = ROT_SHW;
    localparam logic [31:0] OP = 32'h2F6A692D;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rotl_pipe_if #(.WIDTH(W), .SHW(S)) bus ();

    rotl_pipe #(.WIDTH(W), .SHW(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] orig;
        logic [4:0]  amt;
        logic [31:0] res;
    } item_t;

    item_t       exp_q[$];
    item_t       it;
    int unsigned n_checks     = 0;
    int unsigned n_errors     = 0;
    int unsigned n_popped     = 0;
    int unsigned cyc          = 0;
    int unsigned last_pop_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl_m(input logic [31:0] x, input int unsigned n);
        if (n == 0) return x;
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] rotr_m(input logic [31:0] x, input int unsigned n);
        if (n == 0) return x;
        return (x >> n) | (x << (32 - n));
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: handshake levels at the falling edge are the ones the next rising edge commits.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) begin
                it.orig = bus.in_data;
                it.amt  = bus.in_amt;
                it.res  = rotl_m(bus.in_data, bus.in_amt);
                exp_q.push_back(it);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_extra", exp_q.size(), 1);
                end else begin
                    it = exp_q.pop_front();
                    chk("sb_data", bus.out_data, it.res);
                    chk("roundtrip", rotr_m(bus.out_data, it.amt), it.orig);
                end
                n_popped++;
                last_pop_cyc = cyc;
            end
        end
    end

    task automatic send_hold(input logic [31:0] d, input logic [4:0] a);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        chk("accepted", acc, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_one(input string tag, input logic [31:0] d, input logic [4:0] a,
                            input logic [31:0] exp);
        int unsigned lat;
        send_hold(d, a);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 5);
        chk({tag, "_data"}, bus.out_data, exp);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        int unsigned cyc_start;
        int unsigned sent;
        logic        acc;
        logic [31:0] fill_d [6];
        logic [4:0]  fill_a [6];

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Single operands, latency and hand-computed results
        bus.out_ready = 1'b1;
        send_one("amt0",  OP, 5'd0,  32'h2F6A692D);
        send_one("amt1",  OP, 5'd1,  32'h5ED4D25A);
        send_one("amt4",  OP, 5'd4,  32'hF6A692D2);
        send_one("amt8",  OP, 5'd8,  32'h6A692D2F);
        send_one("amt16", OP, 5'd16, 32'h692D2F6A);
        send_one("amt31", OP, 5'd31, 32'h97B53496);
        drain();

        // Back-to-back stream of every amount
        base = n_popped;
        cyc_start = cyc;
        for (int unsigned a = 0; a < 32; a++) send_hold(OP, 5'(a));
        for (int i = 0; i < 100 && n_popped < base + 32; i++) @(posedge clk);
        #1;
        chk("stream_count", n_popped - base, 32);
        chk("stream_span", last_pop_cyc - cyc_start, 36);
        drain();

        // Fill with the consumer stalled, then release
        fill_d = '{32'h2F6A692D, 32'h80000001, 32'hFFFF0000, 32'h12345678, 32'hDEADBEEF, 32'h0F0F0F0F};
        fill_a = '{5'd4, 5'd1, 5'd16, 5'd8, 5'd31, 5'd3};
        bus.out_ready = 1'b0;
        base = n_popped;
        for (int i = 0; i < 5; i++) send_hold(fill_d[i], fill_a[i]);
        bus.in_valid = 1'b1;
        bus.in_data  = fill_d[5];
        bus.in_amt   = fill_a[5];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("full_in_ready", bus.in_ready, 0);
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_out_data", bus.out_data, 32'hF6A692D2);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("simul_in_ready", bus.in_ready, 1);
        chk("simul_out_valid", bus.out_valid, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();
        chk("stall_count", n_popped - base, 6);

        // Random valid/ready traffic
        base = n_popped;
        sent = 0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            if (acc || !bus.in_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = $urandom;
                    bus.in_amt   = 5'($urandom_range(0, 31));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("rand_sent", sent, 10000);
        drain();
        chk("rand_count", n_popped - base, 10000);

        // Reset with three results in flight
        bus.out_ready = 1'b0;
        send_hold(OP, 5'd1);
        send_hold(OP, 5'd8);
        send_hold(OP, 5'd16);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_out_valid", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", bus.out_valid, 0);
        chk("rst_async_data", bus.out_data, 32'h0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_stale", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;
        send_one("post_rst", OP, 5'd31, 32'h97B53496);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rotl_pipe
